// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the parametrised memory controller.
//   state_t   - controller FSM state (CLEAR sweep, READY for requests)
//   MIN_LAT   - smallest supported read latency
//   MAX_LAT   - largest supported read latency
//   lat_ok()  - elaboration-time legality check for READ_LATENCY
package mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int unsigned MIN_LAT = 1;
    localparam int unsigned MAX_LAT = 4;

    function automatic bit lat_ok(int unsigned lat);
        return (lat >= MIN_LAT) && (lat <= MAX_LAT);
    endfunction

endpackage

// File: rtl/memory_ctrl_param_if.sv
// memory_ctrl_param_if: request/response bus between the CPU side and the memory controller.
//   Requester -> memory : sel, rd, wr, ld_ir, address, wdata
//   Memory -> requester : ready, rdata, rvalid, ir_out, ir_valid
//   master modport is the CPU side, slave modport is the memory controller.
interface memory_ctrl_param_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
);

    logic                  sel;
    logic                  rd;
    logic                  wr;
    logic                  ld_ir;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] ir_out;
    logic                  ir_valid;

    modport master (
        output sel, rd, wr, ld_ir, address, wdata,
        input  ready, rdata, rvalid, ir_out, ir_valid
    );

    modport slave (
        input  sel, rd, wr, ld_ir, address, wdata,
        output ready, rdata, rvalid, ir_out, ir_valid
    );

endinterface

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: DEPTH-stage shift register carrying {valid, fetch tag, data} of accepted reads.
//   clk       in   system clock
//   rst       in   synchronous active-low reset, clears every stage
//   in_valid  in   a read was accepted this edge
//   in_tag    in   the accepted read is an instruction fetch
//   in_data   in   array word captured at acceptance
//   out_valid out  read completes this cycle
//   out_tag   out  completing read is a fetch
//   out_data  out  completing read data
module mem_rd_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_tag,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic                  out_tag,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  valid_q [DEPTH];
    logic                  tag_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= 1'b0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            data_q[0]  <= in_data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/memory_ctrl_param.sv
// memory_ctrl_param: parametrised single-port word memory with ready/valid requests,
// pipelined reads, post-reset zero sweep and instruction-register capture.
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-low reset
//   bus  slave side of memory_ctrl_param_if (sel/rd/wr/ld_ir/address/wdata in;
//        ready/rdata/rvalid/ir_out/ir_valid out)
module memory_ctrl_param
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic                clk,
    input logic                rst,
    memory_ctrl_param_if.slave bus
);

    localparam int unsigned MEM_DEPTH = 2 ** ADDR_WIDTH;

    if (!lat_ok(READ_LATENCY)) begin : g_bad_latency
        $error("memory_ctrl_param: READ_LATENCY must lie in 1..4");
    end

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, ir_q;
    logic                  ready, accept, do_read, do_write;
    logic                  pipe_valid, pipe_tag;
    logic [DATA_WIDTH-1:0] pipe_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = READY;
                end
            end
            READY: begin
                clr_addr_d = clr_addr_q;
            end
            default: state_d = CLEAR;
        endcase
    end

    assign ready    = (state_q == READY);
    assign accept   = ready & bus.sel & (bus.rd | bus.wr);
    // Array is never modified on an edge where reset is asserted.
    assign do_write = rst & accept & bus.wr;
    assign do_read  = accept & bus.rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == CLEAR) begin
                mem[clr_addr_q] <= '0;
            end else if (do_write) begin
                mem[bus.address] <= bus.wdata;
            end
        end
    end

    // The word enters the pipe at the accepting edge, so a same-edge or later write
    // cannot disturb it (read-before-write).
    mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (do_read),
        .in_tag    (bus.ld_ir),
        .in_data   (mem[bus.address]),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .out_data  (pipe_data)
    );

    // Hold registers keep the last completed read and fetch visible between pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
            ir_q    <= '0;
        end else begin
            if (pipe_valid) begin
                rdata_q <= pipe_data;
            end
            if (pipe_valid && pipe_tag) begin
                ir_q <= pipe_data;
            end
        end
    end

    always_comb begin
        bus.ready    = ready;
        bus.rvalid   = pipe_valid;
        bus.rdata    = pipe_valid ? pipe_data : rdata_q;
        bus.ir_valid = pipe_valid & pipe_tag;
        bus.ir_out   = (pipe_valid && pipe_tag) ? pipe_data : ir_q;
    end

endmodule

// File: tb/tb_memory_ctrl_param.sv
// tb_memory_ctrl_param: directed self-checking bench driving two controllers
// (READ_LATENCY 1 and 3) with identical stimulus.
module tb_memory_ctrl_param;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel, rd, wr, ld_ir;
    logic [AW-1:0] address;
    logic [DW-1:0] wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_ctrl_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    memory_ctrl_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus3 ();

    assign bus1.sel     = sel;
    assign bus1.rd      = rd;
    assign bus1.wr      = wr;
    assign bus1.ld_ir   = ld_ir;
    assign bus1.address = address;
    assign bus1.wdata   = wdata;
    assign bus3.sel     = sel;
    assign bus3.rd      = rd;
    assign bus3.wr      = wr;
    assign bus3.ld_ir   = ld_ir;
    assign bus3.address = address;
    assign bus3.wdata   = wdata;

    memory_ctrl_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
    ) u_lat1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    memory_ctrl_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3), .CLEAR_ON_RESET(1'b1)
    ) u_lat3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        sel   = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        ld_ir = 1'b0;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sel = 1'b1; rd = 1'b0; wr = 1'b1; ld_ir = 1'b0; address = a; wdata = d;
        step();
        idle();
    endtask

    task automatic start_read(input logic [AW-1:0] a, input logic tag);
        sel = 1'b1; rd = 1'b1; wr = 1'b0; ld_ir = tag; address = a;
    endtask

    task automatic test_reset();
        idle();
        address = '0;
        wdata   = '0;
        rst     = 1'b0;
        step();
        step();
        checks++;
        if (bus1.ready !== 1'b0 || bus1.rvalid !== 1'b0 || bus1.ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got ready=%b rvalid=%b ir_valid=%b want 0 0 0",
                     bus1.ready, bus1.rvalid, bus1.ir_valid);
        end
        checks++;
        if (bus1.rdata !== 8'h00 || bus1.ir_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got rdata=%h ir_out=%h want 00 00", bus1.rdata, bus1.ir_out);
        end
        rst = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (bus1.ready === 1'b1) break;
            step();
        end
        checks++;
        if (bus1.ready !== 1'b1 || bus3.ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_timeout got %b/%b want 1/1", bus1.ready, bus3.ready);
        end
    endtask

    task automatic check_sweep(input string name);
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (bus1.ready !== 1'b0) begin
                failures++;
                $display("FAIL %s_ready_low cycle=%0d got %b want 0", name, k, bus1.ready);
            end
            step();
        end
        checks++;
        if (bus1.ready !== 1'b1 || bus3.ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_high got %b/%b want 1/1", name, bus1.ready, bus3.ready);
        end
    endtask

    task automatic test_reset_sweep();
        write_word(5'd3, 8'hAB);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        check_sweep("sweep");
        start_read(5'd3, 1'b0);
        step();
        idle();
        checks++;
        if (bus1.rvalid !== 1'b1 || bus1.rdata !== 8'h00) begin
            failures++;
            $display("FAIL sweep_cleared got rvalid=%b rdata=%h want 1 00", bus1.rvalid, bus1.rdata);
        end
        step(); step(); step();
    endtask

    task automatic test_write_read();
        write_word(5'd3, 8'hAB);
        write_word(5'd10, 8'h55);
        start_read(5'd3, 1'b0);
        step();
        address = 5'd10;
        checks++;
        if (bus1.rvalid !== 1'b1 || bus1.rdata !== 8'hAB) begin
            failures++;
            $display("FAIL b2b_first got rvalid=%b rdata=%h want 1 ab", bus1.rvalid, bus1.rdata);
        end
        step();
        idle();
        checks++;
        if (bus1.rvalid !== 1'b1 || bus1.rdata !== 8'h55) begin
            failures++;
            $display("FAIL b2b_second got rvalid=%b rdata=%h want 1 55", bus1.rvalid, bus1.rdata);
        end
        step();
        checks++;
        if (bus1.rvalid !== 1'b0 || bus1.rdata !== 8'h55) begin
            failures++;
            $display("FAIL b2b_hold got rvalid=%b rdata=%h want 0 55", bus1.rvalid, bus1.rdata);
        end
        step(); step(); step();
    endtask

    task automatic test_latency3();
        start_read(5'd3, 1'b0);
        step();
        idle();
        step(); step();
        checks++;
        if (bus3.rvalid !== 1'b1 || bus3.rdata !== 8'hAB) begin
            failures++;
            $display("FAIL lat3_pre got rvalid=%b rdata=%h want 1 ab", bus3.rvalid, bus3.rdata);
        end
        step();
        start_read(5'd10, 1'b0);
        step();
        idle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (bus3.rvalid !== 1'b0) begin
                failures++;
                $display("FAIL lat3_early cycle=%0d got rvalid=%b want 0", k, bus3.rvalid);
            end
            step();
        end
        checks++;
        if (bus3.rvalid !== 1'b1 || bus3.rdata !== 8'h55) begin
            failures++;
            $display("FAIL lat3_data got rvalid=%b rdata=%h want 1 55", bus3.rvalid, bus3.rdata);
        end
        step();
        checks++;
        if (bus3.rvalid !== 1'b0 || bus3.rdata !== 8'h55) begin
            failures++;
            $display("FAIL lat3_hold got rvalid=%b rdata=%h want 0 55", bus3.rvalid, bus3.rdata);
        end
        step();
    endtask

    task automatic test_collision();
        write_word(5'd15, 8'h12);
        sel = 1'b1; rd = 1'b1; wr = 1'b1; ld_ir = 1'b0; address = 5'd15; wdata = 8'hFF;
        step();
        idle();
        checks++;
        if (bus1.rvalid !== 1'b1 || bus1.rdata !== 8'h12) begin
            failures++;
            $display("FAIL collide_old got rvalid=%b rdata=%h want 1 12", bus1.rvalid, bus1.rdata);
        end
        step();
        start_read(5'd15, 1'b0);
        step();
        idle();
        checks++;
        if (bus1.rvalid !== 1'b1 || bus1.rdata !== 8'hFF) begin
            failures++;
            $display("FAIL collide_new got rvalid=%b rdata=%h want 1 ff", bus1.rvalid, bus1.rdata);
        end
        step(); step(); step();
    endtask

    task automatic test_fetch_select();
        start_read(5'd3, 1'b1);
        step();
        idle();
        checks++;
        if (bus1.ir_valid !== 1'b1 || bus1.ir_out !== 8'hAB) begin
            failures++;
            $display("FAIL fetch_pulse got ir_valid=%b ir_out=%h want 1 ab",
                     bus1.ir_valid, bus1.ir_out);
        end
        step();
        checks++;
        if (bus1.ir_valid !== 1'b0 || bus1.ir_out !== 8'hAB) begin
            failures++;
            $display("FAIL fetch_one_cycle got ir_valid=%b ir_out=%h want 0 ab",
                     bus1.ir_valid, bus1.ir_out);
        end
        start_read(5'd10, 1'b0);
        step();
        idle();
        checks++;
        if (bus1.rvalid !== 1'b1 || bus1.rdata !== 8'h55 || bus1.ir_out !== 8'hAB
            || bus1.ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL untagged got rvalid=%b rdata=%h ir_out=%h ir_valid=%b want 1 55 ab 0",
                     bus1.rvalid, bus1.rdata, bus1.ir_out, bus1.ir_valid);
        end
        step(); step(); step(); step();
        sel = 1'b0; rd = 1'b1; wr = 1'b0; ld_ir = 1'b1; address = 5'd3;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus1.rvalid !== 1'b0 || bus3.rvalid !== 1'b0 || bus1.rdata !== 8'h55) begin
                failures++;
                $display("FAIL sel_low cycle=%0d got rvalid=%b/%b rdata=%h want 0/0 55",
                         k, bus1.rvalid, bus3.rvalid, bus1.rdata);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        start_read(5'd10, 1'b1);
        step();
        idle();
        rst = 1'b0;
        step();
        checks++;
        if (bus3.rvalid !== 1'b0 || bus3.ir_out !== 8'h00 || bus1.ir_out !== 8'h00) begin
            failures++;
            $display("FAIL midrst_clear got rvalid=%b ir_out=%h/%h want 0 00/00",
                     bus3.rvalid, bus3.ir_out, bus1.ir_out);
        end
        step();
        checks++;
        if (bus3.rvalid !== 1'b0 || bus3.ir_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_discard got rvalid=%b ir_valid=%b want 0 0",
                     bus3.rvalid, bus3.ir_valid);
        end
        rst = 1'b1;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (bus1.ready !== 1'b0) begin
                failures++;
                $display("FAIL partial_sweep cycle=%0d got ready=%b want 0", k, bus1.ready);
            end
            step();
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        check_sweep("restart");
        start_read(5'd10, 1'b0);
        step();
        idle();
        checks++;
        if (bus1.rvalid !== 1'b1 || bus1.rdata !== 8'h00) begin
            failures++;
            $display("FAIL restart_cleared got rvalid=%b rdata=%h want 1 00",
                     bus1.rvalid, bus1.rdata);
        end
        step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_reset_sweep();
        test_write_read();
        test_latency3();
        test_collision();
        test_fetch_select();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_ctrl_param.md
Name: memory_ctrl_param

Overview:
Parametrised successor of the 5x8 unified memory used by the simple CPU datapath.
- Replaces the bidirectional data bus with separate write and read buses.
- Adds a ready/valid handshake, a configurable pipelined read latency and a hardware zero-clear sweep after reset.
- Adds an instruction-register capture path for fetches tagged with ld_ir.
- Sits between the CPU control unit/datapath and the storage array.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 5, address width; MEM_DEPTH = 2**ADDR_WIDTH words.
- READ_LATENCY, 1, cycles from read acceptance to rvalid; legal range 1..4.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents retained, ready immediately.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- sel  in  1  chip select.
- rd  in  1  read request.
- wr  in  1  write request.
- ld_ir  in  1  tags this read as an instruction fetch.
- address  in  ADDR_WIDTH  word address.
- wdata  in  DATA_WIDTH  write data.
- ready  out  1  block accepts requests.
- rdata  out  DATA_WIDTH  read data, held until the next rvalid.
- rvalid  out  1  one-cycle pulse per completed read.
- ir_out  out  DATA_WIDTH  last fetched instruction.
- ir_valid  out  1  one-cycle pulse when ir_out updates.

Behaviour:
- Reset, sampled on the rising edge while rst=0:
  - FSM goes to CLEAR, or READY if CLEAR_ON_RESET=0.
  - clr_addr=0; ready=0; rvalid=0; ir_valid=0; rdata=0; ir_out=0.
  - All in-flight reads are discarded.
  - Array contents are not touched while rst=0.
- FSM state CLEAR:
  - Each edge with rst=1 writes 0 to mem[clr_addr], then increments clr_addr.
  - The edge that writes MEM_DEPTH-1 moves the FSM to READY; ready=1 from the next cycle.
  - Sweep length is exactly MEM_DEPTH cycles (32 at defaults).
  - All requests are ignored in CLEAR and are not queued.
  - rst=0 mid-sweep restarts the sweep from address 0.
- FSM state READY:
  - ready=1.
  - A request is accepted on an edge where sel=1, ready=1 and (rd|wr)=1.
  - sel=0: rd, wr and ld_ir are ignored; outputs hold their values, except rvalid/ir_valid of earlier in-flight reads, which still complete.
- Write: on the accepting edge, mem[address] <= wdata. No response is generated.
- Read:
  - The array is read at the accepting edge, along with address and ld_ir.
  - The data and tag travel through a READ_LATENCY-deep valid/data pipeline.
  - rvalid=1 and rdata are updated in the cycle after edge E+READ_LATENCY-1, where E is the accepting edge.
  - Fully pipelined: one read may be accepted every cycle; rvalid pulses back-to-back in order.
- Simultaneous rd and wr to the same address: read-before-write. The read returns the old word; the array then holds wdata.
- A write accepted while an earlier read to the same address is in flight does not alter that read's data.
- Fetch tag: when a tagged read completes, ir_out <= rdata in the same cycle as rvalid, and ir_valid pulses. Untagged reads leave ir_out unchanged.
- No back-pressure: the consumer must take rdata on rvalid.
- clr_addr and address wrap naturally at ADDR_WIDTH bits; there is no out-of-range condition.

Decomposition:
- Package mem_pkg:
  - state enum: CLEAR, READY.
  - MIN_LAT = 1 and MAX_LAT = 4 constants.
  - A static check that READ_LATENCY lies in 1..4.
- Sub-module mem_rd_pipe: parametrised shift register of {valid, ld_ir, data}, READ_LATENCY stages, cleared by rst.
- The top level holds the FSM, clear counter, array and IR register.

Test Plan:
- Reset sweep:
  - Preload mem[3]=0xAB via a write.
  - Hold rst=0 for 2 cycles, then release.
  - Check ready=0 for exactly 32 cycles, then ready=1.
  - Read address 3 and check rdata=0x00.
- Write then read at READ_LATENCY=1:
  - Write 0xAB to address 3 and 0x55 to address 10.
  - Issue back-to-back reads of 3 then 10.
  - Check rvalid on two consecutive cycles with rdata=0xAB then 0x55.
- READ_LATENCY=3:
  - Issue a read of address 10 holding 0x55.
  - Check rvalid exactly 3 cycles after acceptance, rdata=0x55, and rdata held afterwards.
- Same-address collision:
  - mem[15]=0x12.
  - Issue sel=1, rd=1, wr=1, address 15, wdata=0xFF.
  - Check the read returns 0x12 and a following read returns 0xFF.
- Fetch and select:
  - Tagged read (ld_ir=1) of address 3 holding 0xAB: check ir_out=0xAB with a one-cycle ir_valid pulse.
  - Untagged read of address 10: check ir_out stays 0xAB.
  - sel=0 with rd=1: check no rvalid.
- Reset mid-operation:
  - Issue a read at READ_LATENCY=3, then assert rst one cycle later.
  - Check no rvalid and ir_out=0.
  - Re-assert rst at clear address 7: check the sweep restarts and ready returns 32 cycles after release.
